control_sequencer: RTL and testbench
====================================

# control_sequencer

Multi-cycle control unit for the 8-bit accumulator computer. Sequences each instruction through fetch and execute, drives the register loads, the ALU-input selectors and the ALU operation, latches ALU flags and steers the program counter (increment or jump). It replaces the purely combinational opcode decode.

## Interface
Parameters:
- `RESET_PC`, 8'h00: value presented on `pc_target` with `pc_load` during the first cycle after reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr`  in  16  instruction-memory output; opcode = `instr[15:9]`, K = `instr[7:0]`.
- `stall`  in  1  instruction memory not ready; holds FETCH.
- `alu_z`, `alu_n`, `alu_c`, `alu_v`  in  1 each  combinational ALU flags.
- `la`, `lb`  out  1  load register A / B.
- `sel_a`  out  2  ALU A input: 00 regA, 01 regB, 10 zero, 11 one.
- `sel_b`  out  2  ALU B input: 00 regB, 01 regA, 10 K, 11 zero.
- `alu_op`  out  4  0000 ADD; 1001 idle.
- `k_out`  out  8  K from the instruction register.
- `pc_inc`  out  1  advance PC by one.
- `pc_load`  out  1  load PC from `pc_target`; overrides `pc_inc`.
- `pc_target`  out  8  jump address.
- `flags`  out  4  latched {Z,N,C,V}.
- `halted`  out  1  HALT state reached.

## Operation
- Reset and clock: one clock `clk`; reset `rst` is asynchronous and active-high.
- States: INIT, FETCH, EXEC, HALT.
- Reset state is INIT. Reset clears the IR, `flags` and `halted`. All outputs are 0, except `alu_op`=1001 and `pc_target`=`RESET_PC`.
- INIT:
  - Asserts `pc_load` with `pc_target`=`RESET_PC` for one cycle.
  - Then moves to FETCH.
- FETCH:
  - If `stall`=1, stays in FETCH with IR unchanged.
  - Otherwise latches `instr` into the IR and moves to EXEC.
  - No loads and no PC control are asserted in FETCH.
- EXEC: decodes the IR combinationally and lasts exactly one cycle.
  - 0000000 A=B: `la`, `sel_a`=10, `sel_b`=00, ADD.
  - 0000001 B=A: `lb`, `sel_a`=10, `sel_b`=01, ADD.
  - 0000010 A=K: `la`, `sel_a`=10, `sel_b`=10, ADD.
  - 0000011 B=K: `lb`, `sel_a`=10, `sel_b`=10, ADD.
  - 0000100 A=A+B: `la`, `sel_a`=00, `sel_b`=00, ADD.
  - 0000101 B=A+B: `lb`, `sel_a`=00, `sel_b`=00, ADD.
  - 0000110 A=A+K: `la`, `sel_a`=00, `sel_b`=10, ADD.
  - 0000111 B=B+K: `lb`, `sel_a`=01, `sel_b`=10, ADD.
  - 1000000 JMP K: always taken.
  - 1000001 JEQ K: taken if `flags`.Z=1.
  - 1000010 JNE K: taken if `flags`.Z=0.
  - 1000011 JN K: taken if `flags`.N=1.
  - 1111111 HLT: goes to HALT with no PC change.
  - Any other opcode is a NOP: no loads, PC increments.
- Flags:
  - Opcodes 0000000–0000111 latch {`alu_z`,`alu_n`,`alu_c`,`alu_v`} into `flags` at the end of EXEC.
  - Jumps, HLT and NOP leave `flags` unchanged.
  - Jump conditions use the latched `flags`, never the live ALU flags.
- PC control:
  - A taken jump asserts `pc_load` with `pc_target`=K and `pc_inc`=0.
  - Any other non-HLT instruction asserts `pc_inc`.
  - `pc_inc` and `pc_load` are never high together.
- HALT: `halted`=1 and all loads and PC controls are 0. Only `rst` exits HALT.
- `k_out` is always IR[7:0], including outside EXEC.

## Timing
- Every instruction takes 2 cycles (FETCH + EXEC) when `stall`=0. Each `stall` cycle adds one cycle.
- Control outputs are Moore/IR-decoded and stable for the whole EXEC cycle. The register load, flags latch and PC update all occur on the EXEC→FETCH edge.
- `pc_inc` or `pc_load` is high for exactly one cycle per executed instruction.
- The PC wraps naturally: 8'hFF plus increment gives 8'h00. Sequencer behaviour is unaffected.
- `stall` is sampled only in FETCH and ignored in EXEC, HALT and INIT.
- `rst` asserted mid-EXEC forces INIT immediately. The pending load and PC update are suppressed, because the outputs go to their reset values asynchronously.

## Test plan
- Reset, then release → one cycle of `pc_load`=1 with `pc_target`=00, then FETCH. `flags`=0, `halted`=0.
- A=K(5) then A=A+K(8'hFB) → first EXEC: `la`=1, `sel_b`=10, `k_out`=05. Second EXEC: ADD, then `flags`={1,0,1,0} latched. Both EXECs assert `pc_inc`.
- Following JEQ 8'h20 with Z=1 → `pc_load`=1, `pc_target`=20, `pc_inc`=0. JNE 8'h20 in the same condition → `pc_inc`=1 only.
- `stall` held high for 3 cycles in FETCH → IR unchanged and no control pulses. EXEC starts the cycle after `stall` falls; total 5 cycles for that instruction.
- HLT (16'hFE00) → `halted`=1 from the next cycle, all controls 0 for 20 cycles, and no `pc_inc`.
- `rst` pulsed asynchronously mid-EXEC of A=A+B → `la` drops immediately, `flags` cleared, and the sequence restarts with INIT.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle control unit for the 8-bit accumulator computer: INIT/FETCH/EXEC/HALT
// sequencing, IR-decoded register loads, ALU steering, flag latching and PC control.
module control_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] instr_i,
    input  logic        stall_i,
    input  logic        alu_z_i,
    input  logic        alu_n_i,
    input  logic        alu_c_i,
    input  logic        alu_v_i,
    output logic        la_o,
    output logic        lb_o,
    output logic [1:0]  sel_a_o,
    output logic [1:0]  sel_b_o,
    output logic [3:0]  alu_op_o,
    output logic [7:0]  k_out_o,
    output logic        pc_inc_o,
    output logic        pc_load_o,
    output logic [7:0]  pc_target_o,
    output logic [3:0]  flags_o,
    output logic        halted_o
);
    typedef enum logic [1:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_HALT} state_t;

    localparam logic [6:0] OP_HLT   = 7'h7F;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_IDLE = 4'b1001;

    state_t     state_q;
    logic [6:0] op_q;
    logic [7:0] k_q;
    logic [3:0] flags_q;
    logic       halted_q;
    logic       is_data;
    logic       is_jump;
    logic       jump_taken;
    logic       unused_bit;

    assign unused_bit = instr_i[8];
    assign is_data    = (op_q[6:3] == 4'b0000);
    assign is_jump    = (op_q[6:2] == 5'b10000);

    // Jump conditions look only at the latched flags, never the live ALU outputs.
    always_comb begin
        jump_taken = 1'b0;
        case (op_q[1:0])
            2'b00:   jump_taken = 1'b1;
            2'b01:   jump_taken = flags_q[3];
            2'b10:   jump_taken = ~flags_q[3];
            default: jump_taken = flags_q[2];
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_INIT;
            op_q     <= 7'd0;
            k_q      <= 8'd0;
            flags_q  <= 4'd0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (!stall_i) begin
                        op_q    <= instr_i[15:9];
                        k_q     <= instr_i[7:0];
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_data) begin
                        flags_q <= {alu_z_i, alu_n_i, alu_c_i, alu_v_i};
                    end
                    if (op_q == OP_HLT) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    // Reset is folded in so the controls fall back the instant rst rises, even mid-EXEC.
    always_comb begin
        la_o        = 1'b0;
        lb_o        = 1'b0;
        sel_a_o     = 2'b00;
        sel_b_o     = 2'b00;
        alu_op_o    = ALU_IDLE;
        pc_inc_o    = 1'b0;
        pc_load_o   = 1'b0;
        pc_target_o = RESET_PC;
        if (!rst_i) begin
            case (state_q)
                ST_INIT: pc_load_o = 1'b1;
                ST_EXEC: begin
                    if (is_data) begin
                        la_o     = ~op_q[0];
                        lb_o     = op_q[0];
                        alu_op_o = ALU_ADD;
                        pc_inc_o = 1'b1;
                        sel_a_o  = op_q[2] ? ((op_q[1:0] == 2'b11) ? 2'b01 : 2'b00) : 2'b10;
                        case (op_q[2:0])
                            3'd0, 3'd4, 3'd5: sel_b_o = 2'b00;
                            3'd1:             sel_b_o = 2'b01;
                            default:          sel_b_o = 2'b10;
                        endcase
                    end else if (is_jump) begin
                        pc_target_o = k_q;
                        pc_load_o   = jump_taken;
                        pc_inc_o    = ~jump_taken;
                    end else if (op_q != OP_HLT) begin
                        pc_inc_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign k_out_o  = k_q;
    assign flags_o  = flags_q;
    assign halted_o = halted_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: an instruction-level model (registers A/B,
// ADD flags, latched flags) predicts every control output, checked each cycle.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        stall;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic        la, lb, pc_inc, pc_load, halted;
    logic [1:0]  sel_a, sel_b;
    logic [3:0]  alu_op, flags;
    logic [7:0]  k_out, pc_target;

    control_sequencer #(.RESET_PC(8'h00)) dut (
        .clk_i(clk), .rst_i(rst), .instr_i(instr), .stall_i(stall),
        .alu_z_i(alu_z), .alu_n_i(alu_n), .alu_c_i(alu_c), .alu_v_i(alu_v),
        .la_o(la), .lb_o(lb), .sel_a_o(sel_a), .sel_b_o(sel_b), .alu_op_o(alu_op),
        .k_out_o(k_out), .pc_inc_o(pc_inc), .pc_load_o(pc_load),
        .pc_target_o(pc_target), .flags_o(flags), .halted_o(halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected outputs for the current cycle
    logic       check_en = 1'b0;
    logic       e_la, e_lb, e_pinc, e_pload, e_halt, e_chk_sel, e_chk_tgt;
    logic [1:0] e_sa, e_sb;
    logic [3:0] e_op, e_flags;
    logic [7:0] e_k, e_tgt;

    // Instruction-level machine model
    logic [7:0] m_a, m_b, m_k;
    logic [3:0] m_flags;
    logic       m_halted;
    int         p_dst;
    logic [7:0] p_val;
    logic [3:0] p_flags;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("la", 16'(la), 16'(e_la));
            chk("lb", 16'(lb), 16'(e_lb));
            chk("pc_inc", 16'(pc_inc), 16'(e_pinc));
            chk("pc_load", 16'(pc_load), 16'(e_pload));
            chk("halted", 16'(halted), 16'(e_halt));
            chk("flags", 16'(flags), 16'(e_flags));
            chk("k_out", 16'(k_out), 16'(e_k));
            if (e_chk_sel) begin
                chk("sel_a", 16'(sel_a), 16'(e_sa));
                chk("sel_b", 16'(sel_b), 16'(e_sb));
                chk("alu_op", 16'(alu_op), 16'(e_op));
            end
            if (e_chk_tgt) chk("pc_target", 16'(pc_target), 16'(e_tgt));
        end
    end

    function automatic logic [3:0] add_flags(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {s[7:0] == 8'h00, s[7], s[8], (a[7] == b[7]) && (s[7] != a[7])};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_alu();
        {alu_z, alu_n, alu_c, alu_v} = 4'($urandom);
    endtask

    task automatic set_idle();
        {e_la, e_lb, e_pinc, e_pload} = 4'b0000;
        e_halt = m_halted; e_flags = m_flags; e_k = m_k;
        e_chk_sel = 1'b0; e_chk_tgt = 1'b0;
        e_sa = 2'b00; e_sb = 2'b00; e_op = 4'b1001; e_tgt = 8'h00;
    endtask

    task automatic model_reset();
        m_flags = 4'h0; m_k = 8'h00; m_halted = 1'b0;
        set_idle();
        e_chk_sel = 1'b1; e_chk_tgt = 1'b1;
    endtask

    task automatic set_init();
        set_idle();
        e_pload = 1'b1; e_chk_tgt = 1'b1; e_tgt = 8'h00;
    endtask

    task automatic fetch(input logic [15:0] ins, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1; instr = 16'($urandom); rand_alu(); set_idle(); step();
        end
        stall = 1'b0; instr = ins; rand_alu(); set_idle(); step();
        m_k = ins[7:0];
    endtask

    // Sets expectations for the EXEC cycle and drives the ALU flags an ADD would produce
    task automatic exec_start(input logic [15:0] ins);
        logic [6:0] op;
        logic [7:0] x, y, k;
        logic       taken;
        op = ins[15:9]; k = ins[7:0];
        stall = 1'(($urandom)); instr = 16'($urandom);
        set_idle();
        p_dst = 0; x = 8'h00; y = 8'h00;
        case (op)
            7'h00: begin e_la = 1; e_sa = 2'b10; e_sb = 2'b00; y = m_b; p_dst = 1; end
            7'h01: begin e_lb = 1; e_sa = 2'b10; e_sb = 2'b01; y = m_a; p_dst = 2; end
            7'h02: begin e_la = 1; e_sa = 2'b10; e_sb = 2'b10; y = k;   p_dst = 1; end
            7'h03: begin e_lb = 1; e_sa = 2'b10; e_sb = 2'b10; y = k;   p_dst = 2; end
            7'h04: begin e_la = 1; e_sa = 2'b00; e_sb = 2'b00; x = m_a; y = m_b; p_dst = 1; end
            7'h05: begin e_lb = 1; e_sa = 2'b00; e_sb = 2'b00; x = m_a; y = m_b; p_dst = 2; end
            7'h06: begin e_la = 1; e_sa = 2'b00; e_sb = 2'b10; x = m_a; y = k;   p_dst = 1; end
            7'h07: begin e_lb = 1; e_sa = 2'b01; e_sb = 2'b10; x = m_b; y = k;   p_dst = 2; end
            default: ;
        endcase
        if (p_dst != 0) begin
            e_op = 4'b0000; e_pinc = 1; e_chk_sel = 1;
            p_val = x + y; p_flags = add_flags(x, y);
            {alu_z, alu_n, alu_c, alu_v} = p_flags;
        end else if (op >= 7'h40 && op <= 7'h43) begin
            taken = (op == 7'h40) || (op == 7'h41 && m_flags[3]) ||
                    (op == 7'h42 && !m_flags[3]) || (op == 7'h43 && m_flags[2]);
            e_pload = taken; e_pinc = !taken; e_chk_tgt = taken; e_tgt = k;
            {alu_z, alu_n, alu_c, alu_v} = ~m_flags;
        end else begin
            e_pinc = (op != 7'h7F);
            rand_alu();
        end
    endtask

    task automatic exec_finish(input logic [15:0] ins);
        step();
        if (p_dst == 1) m_a = p_val;
        if (p_dst == 2) m_b = p_val;
        if (p_dst != 0) m_flags = p_flags;
        if (ins[15:9] == 7'h7F) m_halted = 1'b1;
        set_idle();
    endtask

    task automatic run(input logic [15:0] ins, input int stalls);
        fetch(ins, stalls);
        exec_start(ins);
        exec_finish(ins);
        $display("instr %h stalls %0d -> A=%h B=%h flags=%b halted=%b", ins, stalls, m_a, m_b, m_flags, m_halted);
    endtask

    task automatic do_reset();
        rst = 1'b1; model_reset(); step(); step();
        rst = 1'b0; set_init(); step();
    endtask

    initial begin
        rst = 1'b1; instr = 16'h0; stall = 1'b0; rand_alu();
        m_a = 8'h00; m_b = 8'h00; p_dst = 0; p_val = 8'h00; p_flags = 4'h0;
        model_reset();
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; set_init(); step();

        // A=K 05 with literal pins on the EXEC cycle
        fetch(16'h0405, 0);
        exec_start(16'h0405);
        @(negedge clk); #1;
        chk("lit_k_out", 16'(k_out), 16'h0005);
        chk("lit_sel_b", 16'(sel_b), 16'h0002);
        exec_finish(16'h0405);
        run(16'h0CFB, 0);                               // A=A+K FB -> 0x100
        chk("lit_model_flags", 16'(m_flags), 16'h000A);
        chk("lit_flags", 16'(flags), 16'h000A);
        fetch(16'h8220, 0);                             // JEQ 20, Z=1 -> taken
        exec_start(16'h8220);
        @(negedge clk); #1;
        chk("lit_jeq_tgt", 16'(pc_target), 16'h0020);
        chk("lit_jeq_inc", 16'(pc_inc), 16'h0000);
        exec_finish(16'h8220);
        run(16'h8420, 0);                               // JNE 20, not taken
        run(16'h0680, 3);                               // B=K 80 with three stall cycles
        run(16'h0E80, 0);                               // B=B+K 80 -> Z,C,V
        chk("lit_bbk_flags", 16'(flags), 16'h000B);
        run(16'h0200, 1);                               // B=A
        run(16'h0000, 0);                               // A=B
        run(16'h047F, 0);
        run(16'h0601, 2);
        run(16'h0800, 0);                               // A=A+B -> 0x80, N,V
        run(16'h8633, 0);                               // JN 33 taken
        run(16'h8244, 0);                               // JEQ not taken
        run(16'h80FF, 0);                               // JMP FF
        run(16'h2000, 0);                               // NOP
        run(16'h0A00, 0);                               // B=A+B
        run(16'hFE00, 0);                               // HLT
        for (int i = 0; i < 20; i++) begin
            stall = 1'(($urandom)); instr = 16'($urandom); rand_alu(); set_idle(); step();
        end

        do_reset();
        run(16'h0480, 0);                               // A=K 80 -> N latched
        fetch(16'h0800, 0);
        exec_start(16'h0800);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_la", 16'(la), 16'h0000);
        chk("rst_flags", 16'(flags), 16'h0000);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0; set_init(); step();
        run(16'h0411, 0);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
